// File: rtl/axi_rd_arbiter_2to1_pkg.sv
// Shared AXI read-channel field widths and arbiter state encoding for the
// 2:1 read arbiter between instruction fetch and the L1 data cache.
package vex_axi_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // A beat is mis-framed when rlast disagrees with the remaining-beat count.
  function automatic logic beat_len_err(input logic rlast, input logic [LEN_W-1:0] beat_left);
    logic err;
    if (rlast) begin
      err = (beat_left != {LEN_W{1'b0}});
    end else begin
      err = (beat_left == {LEN_W{1'b0}});
    end
    return err;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_2to1_if.sv
// AXI4 read address/data channel bundle. "master" drives AR and rready,
// "slave" drives arready and the R payload.
interface axi_rd_arbiter_2to1_if
  import vex_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic               arvalid;
  logic               arready;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic [CACHE_W-1:0] arcache;
  logic [PROT_W-1:0]  arprot;

  logic               rvalid;
  logic               rready;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arcache, arprot, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arcache, arprot, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axi_rd_arbiter_2to1_rr_arb2.sv
// Two-requester round-robin picker. Holds the favoured-requester pointer,
// which the owner advances with an explicit update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_ptr_i,
  output logic [1:0] win_oh_o,
  output logic       win_idx_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Winner selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    win_idx_o = 1'b0;
    win_oh_o  = 2'b00;
    case (req_i)
      2'b01: begin
        win_idx_o = 1'b0;
        win_oh_o  = 2'b01;
      end
      2'b10: begin
        win_idx_o = 1'b1;
        win_oh_o  = 2'b10;
      end
      2'b11: begin
        win_idx_o = rr_ptr_q;
        win_oh_o  = rr_ptr_q ? 2'b10 : 2'b01;
      end
      default: begin
        win_idx_o = 1'b0;
        win_oh_o  = 2'b00;
      end
    endcase
  end

  // Pointer next-state.
  always_comb begin
    if (upd_i) begin
      rr_ptr_d = upd_ptr_i;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register; requester 0 is favoured out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Shares one AXI4 read port between instruction fetch (s0) and the L1 data
// cache (s1): round-robin grant, a single outstanding burst, R routed to the owner.
module axi_rd_arbiter_2to1
  import vex_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_rd_arbiter_2to1_if.slave         s0_if,
  axi_rd_arbiter_2to1_if.slave         s1_if,
  axi_rd_arbiter_2to1_if.master        m_if,
  output logic                         err_len_o,
  output logic                         busy_o
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADDR = ADDR;
  localparam logic [1:0] ST_DATA = DATA;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [LEN_W-1:0] beat_left_q, beat_left_d;
  logic             err_len_q, err_len_d;
  logic             busy_q, busy_d;

  logic [1:0]       req_s;
  logic [1:0]       win_oh_s;
  logic             win_idx_s;
  logic             any_req_s;
  logic             upd_s;
  logic             in_addr_s;
  logic             in_data_s;
  logic             ar_hs_s;
  logic             r_hs_s;

  logic               sel_arvalid_s;
  logic [ADDR_W-1:0]  sel_araddr_s;
  logic [LEN_W-1:0]   sel_arlen_s;
  logic [SIZE_W-1:0]  sel_arsize_s;
  logic [BURST_W-1:0] sel_arburst_s;
  logic [CACHE_W-1:0] sel_arcache_s;
  logic [PROT_W-1:0]  sel_arprot_s;
  logic               sel_rready_s;
  logic [DATA_W-1:0]  rdata_s;

  assign req_s     = {s1_if.arvalid, s0_if.arvalid};
  assign any_req_s = |win_oh_s;
  assign in_addr_s = (state_q == ST_ADDR);
  assign in_data_s = (state_q == ST_DATA);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_s),
    .upd_i     (upd_s),
    .upd_ptr_i (~gnt_q),
    .win_oh_o  (win_oh_s),
    .win_idx_o (win_idx_s)
  );

  // AR field and rready selection from the registered grant.
  always_comb begin
    if (gnt_q) begin
      sel_arvalid_s = s1_if.arvalid;
      sel_araddr_s  = s1_if.araddr;
      sel_arlen_s   = s1_if.arlen;
      sel_arsize_s  = s1_if.arsize;
      sel_arburst_s = s1_if.arburst;
      sel_arcache_s = s1_if.arcache;
      sel_arprot_s  = s1_if.arprot;
      sel_rready_s  = s1_if.rready;
    end else begin
      sel_arvalid_s = s0_if.arvalid;
      sel_araddr_s  = s0_if.araddr;
      sel_arlen_s   = s0_if.arlen;
      sel_arsize_s  = s0_if.arsize;
      sel_arburst_s = s0_if.arburst;
      sel_arcache_s = s0_if.arcache;
      sel_arprot_s  = s0_if.arprot;
      sel_rready_s  = s0_if.rready;
    end
  end

  assign ar_hs_s = in_addr_s & sel_arvalid_s & m_if.arready;
  assign r_hs_s  = in_data_s & m_if.rvalid & sel_rready_s;

  // Withdrawn arvalid in ADDR simply drops m_arvalid, so nothing is issued.
  assign m_if.arvalid = in_addr_s & sel_arvalid_s;
  assign m_if.araddr  = sel_araddr_s;
  assign m_if.arlen   = sel_arlen_s;
  assign m_if.arsize  = sel_arsize_s;
  assign m_if.arburst = sel_arburst_s;
  assign m_if.arcache = sel_arcache_s;
  assign m_if.arprot  = sel_arprot_s;
  assign s0_if.arready = in_addr_s & ~gnt_q & m_if.arready;
  assign s1_if.arready = in_addr_s &  gnt_q & m_if.arready;

  // Stray memory beats outside DATA are neither accepted nor forwarded.
  assign m_if.rready  = in_data_s & sel_rready_s;
  assign rdata_s      = m_if.rdata;
  assign s0_if.rvalid = in_data_s & ~gnt_q & m_if.rvalid;
  assign s1_if.rvalid = in_data_s &  gnt_q & m_if.rvalid;
  assign s0_if.rdata  = rdata_s;
  assign s1_if.rdata  = rdata_s;
  assign s0_if.rresp  = m_if.rresp;
  assign s1_if.rresp  = m_if.rresp;
  assign s0_if.rlast  = m_if.rlast;
  assign s1_if.rlast  = m_if.rlast;

  // FSM, beat counter and sticky framing error; the burst ends only on rlast.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    beat_left_d = beat_left_q;
    err_len_d   = err_len_q;
    upd_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_ADDR;
          gnt_d   = win_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          beat_left_d = sel_arlen_s;
          state_d     = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_hs_s) begin
          if (beat_len_err(m_if.rlast, beat_left_q)) begin
            err_len_d = 1'b1;
          end else begin
            err_len_d = err_len_q;
          end
          if (beat_left_q != 8'd0) begin
            beat_left_d = beat_left_q - 8'd1;
          end else begin
            beat_left_d = beat_left_q;
          end
          if (m_if.rlast) begin
            state_d = ST_IDLE;
            upd_s   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers; reset abandons any in-flight burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      beat_left_q <= 8'd0;
      err_len_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      beat_left_q <= beat_left_d;
      err_len_q   <= err_len_d;
      busy_q      <= busy_d;
    end
  end

  assign err_len_o = err_len_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Directed-plus-random bench for the 2:1 AXI read arbiter with a transaction
// level model of grants, beat routing and burst framing errors.
module tb_axi_rd_arbiter_2to1;
  import vex_axi_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic err_len;
  logic busy;

  always #5 clk = ~clk;

  axi_rd_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(64)) s0_if ();
  axi_rd_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(64)) s1_if ();
  axi_rd_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(64)) m_if ();

  axi_rd_arbiter_2to1 #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .s0_if     (s0_if),
    .s1_if     (s1_if),
    .m_if      (m_if),
    .err_len_o (err_len),
    .busy_o    (busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: favoured master, sticky error, pending requests and their fields.
  int         model_ptr;
  logic       model_err;
  bit         active [2];
  logic [31:0] ex_addr  [2];
  logic [7:0]  ex_len   [2];
  logic [2:0]  ex_size  [2];
  logic [1:0]  ex_burst [2];
  logic [3:0]  ex_cache [2];
  logic [2:0]  ex_prot  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic s_rvalid(input int m);
    return (m == 0) ? s0_if.rvalid : s1_if.rvalid;
  endfunction
  function automatic logic s_rready(input int m);
    return (m == 0) ? s0_if.rready : s1_if.rready;
  endfunction
  function automatic logic s_arready(input int m);
    return (m == 0) ? s0_if.arready : s1_if.arready;
  endfunction
  function automatic logic [63:0] s_rdata(input int m);
    return (m == 0) ? s0_if.rdata : s1_if.rdata;
  endfunction
  function automatic logic [2:0] s_rresp_last(input int m);
    return (m == 0) ? {s0_if.rresp, s0_if.rlast} : {s1_if.rresp, s1_if.rlast};
  endfunction
  function automatic logic [51:0] m_ar_fields();
    return {m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arcache, m_if.arprot};
  endfunction

  function automatic int exp_winner();
    if (active[0] && active[1]) return model_ptr;
    else if (active[1]) return 1;
    else return 0;
  endfunction

  task automatic set_rready(input int m, input logic v);
    if (m == 0) s0_if.rready = v;
    else s1_if.rready = v;
  endtask

  task automatic drive_req(input int m, input logic [31:0] a, input logic [7:0] l);
    ex_addr[m]  = a;
    ex_len[m]   = l;
    ex_size[m]  = 3'($urandom);
    ex_burst[m] = 2'($urandom_range(0, 2));
    ex_cache[m] = 4'($urandom);
    ex_prot[m]  = 3'($urandom);
    active[m]   = 1'b1;
    if (m == 0) begin
      s0_if.arvalid = 1'b1; s0_if.araddr = a; s0_if.arlen = l; s0_if.arsize = ex_size[m];
      s0_if.arburst = ex_burst[m]; s0_if.arcache = ex_cache[m]; s0_if.arprot = ex_prot[m];
    end else begin
      s1_if.arvalid = 1'b1; s1_if.araddr = a; s1_if.arlen = l; s1_if.arsize = ex_size[m];
      s1_if.arburst = ex_burst[m]; s1_if.arcache = ex_cache[m]; s1_if.arprot = ex_prot[m];
    end
  endtask

  task automatic drop_req(input int m);
    active[m] = 1'b0;
    if (m == 0) s0_if.arvalid = 1'b0;
    else s1_if.arvalid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 64'({m_if.arvalid, m_if.rready, s0_if.arready, s1_if.arready,
                  s0_if.rvalid, s1_if.rvalid, err_len, busy}), 64'd0);
  endtask

  // Wait for the grant's AR to reach memory, optionally stall it, then accept it.
  task automatic serve_ar(input int w, input int stall);
    logic [51:0] exp_f;
    int lat;
    exp_f = {ex_addr[w], ex_len[w], ex_size[w], ex_burst[w], ex_cache[w], ex_prot[w]};
    lat = 0;
    @(negedge clk);
    while (m_if.arvalid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    chk("ar_latency", 64'(lat), 64'd1);
    chk("ar_fields", 64'(m_ar_fields()), 64'(exp_f));
    for (int i = 0; i < stall; i++) begin
      chk("ar_stall_gated", 64'({s_arready(1), s_arready(0)}), 64'd0);
      @(negedge clk);
      chk("ar_stable", 64'({m_if.arvalid, m_ar_fields()}), 64'({1'b1, exp_f}));
    end
    m_if.arready = 1'b1;
    #1;
    chk("arready_route", 64'({s_arready(1), s_arready(0)}), (w == 1) ? 64'd2 : 64'd1);
    @(posedge clk);
    #1;
    m_if.arready = 1'b0;
    drop_req(w);
  endtask

  // Memory side of a burst: rlast on beat index last_at; data held while stalled.
  task automatic serve_r(input int w, input int last_at, input bit toggle, input int stop_after);
    int sent, rcvd, cyc;
    logic [63:0] d;
    logic [1:0] rs;
    logic ph, want, rx, mr;
    sent = 0; rcvd = 0; cyc = 0; ph = 1'b1;
    d = {$urandom, $urandom};
    rs = 2'($urandom);
    while (sent <= last_at && cyc < 200 && sent != stop_after) begin
      want = toggle ? ph : 1'b1;
      m_if.rvalid = 1'b1; m_if.rdata = d; m_if.rresp = rs; m_if.rlast = (sent == last_at);
      set_rready(w, want);
      set_rready(1 - w, 1'($urandom));
      @(negedge clk);
      chk("r_route", 64'({s_rvalid(w), s_rvalid(1 - w)}), 64'd2);
      chk("r_data", s_rdata(w), d);
      chk("r_resp_last", 64'(s_rresp_last(w)), 64'({rs, (sent == last_at)}));
      chk("r_ready_fwd", 64'(m_if.rready), 64'(want));
      chk("busy_data", 64'(busy), 64'd1);
      rx = s_rvalid(w) & s_rready(w);
      mr = m_if.rready;
      @(posedge clk);
      #1;
      if (rx === 1'b1) rcvd++;
      if (mr === 1'b1) begin
        sent++;
        d = {$urandom, $urandom};
        rs = 2'($urandom);
      end
      ph = ~ph;
      cyc++;
    end
    m_if.rvalid = 1'b0;
    m_if.rlast = 1'b0;
    chk("beat_conservation", 64'(rcvd), 64'(sent));
    if (stop_after < 0) chk("beat_count", 64'(sent), 64'(last_at + 1));
  endtask

  task automatic do_burst(input int stall, input bit toggle, input int last_at);
    int w, la;
    w = exp_winner();
    la = (last_at < 0) ? int'(ex_len[w]) : last_at;
    serve_ar(w, stall);
    serve_r(w, la, toggle, -1);
    if (la != int'(ex_len[w])) model_err = 1'b1;
    model_ptr = 1 - w;
    chk("err_len", 64'(err_len), 64'(model_err));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s0_if.arvalid = 1'b0; s0_if.araddr = 32'd0; s0_if.arlen = 8'd0; s0_if.arsize = 3'd0;
    s0_if.arburst = 2'd0; s0_if.arcache = 4'd0; s0_if.arprot = 3'd0; s0_if.rready = 1'b0;
    s1_if.arvalid = 1'b0; s1_if.araddr = 32'd0; s1_if.arlen = 8'd0; s1_if.arsize = 3'd0;
    s1_if.arburst = 2'd0; s1_if.arcache = 4'd0; s1_if.arprot = 3'd0; s1_if.rready = 1'b0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = 64'd0; m_if.rresp = 2'd0; m_if.rlast = 1'b0;
    model_ptr = 0; model_err = 1'b0; active[0] = 1'b0; active[1] = 1'b0;

    @(negedge clk);
    chk_reset("reset_init");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single IC burst.
    drive_req(0, 32'h8000_0000, 8'd3);
    do_burst(0, 1'b0, -1);

    // Reset while beat 2 of 4 is on the bus.
    drive_req(0, $urandom, 8'd3);
    serve_ar(0, 0);
    serve_r(0, 3, 1'b0, 2);
    m_if.rvalid = 1'b1;
    m_if.rdata = {$urandom, $urandom};
    s0_if.rready = 1'b1;
    reset = 1'b1;
    #1;
    chk_reset("reset_async");
    @(negedge clk);
    chk_reset("reset_mid_burst");
    @(posedge clk); #1;
    reset = 1'b0;
    model_ptr = 0; model_err = 1'b0;
    @(negedge clk);
    chk_reset("post_reset_idle");
    @(posedge clk); #1;
    m_if.rvalid = 1'b0;

    // Contention: s0 first, then s1, then alternation.
    drive_req(0, $urandom, 8'd7);
    drive_req(1, $urandom, 8'd0);
    do_burst(0, 1'b0, -1);
    do_burst(0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      if (!active[0]) drive_req(0, $urandom, 8'($urandom_range(0, 3)));
      if (!active[1]) drive_req(1, $urandom, 8'($urandom_range(0, 3)));
      do_burst(0, 1'b0, -1);
    end
    drop_req(0);
    drop_req(1);

    // Backpressure on both AR and R.
    drive_req(1, $urandom, 8'($urandom_range(2, 7)));
    do_burst(5, 1'b1, -1);

    // Stray memory beat while idle.
    m_if.rvalid = 1'b1;
    m_if.rlast = 1'b1;
    s0_if.rready = 1'b1;
    s1_if.rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_ignored", 64'({m_if.rready, s0_if.rvalid, s1_if.rvalid, busy, m_if.arvalid}), 64'd0);
    end
    @(posedge clk); #1;
    m_if.rvalid = 1'b0;
    m_if.rlast = 1'b0;
    drive_req(0, $urandom, 8'($urandom_range(0, 3)));
    do_burst(0, 1'b0, -1);

    // Early rlast sets the sticky error; later traffic proceeds normally.
    drive_req(0, $urandom, 8'd3);
    do_burst(0, 1'b0, 2);
    drive_req(1, $urandom, 8'($urandom_range(0, 4)));
    do_burst(0, 1'b0, -1);

    // Random mix of requesters, stalls and rready patterns.
    for (int i = 0; i < 8; i++) begin
      int pick;
      pick = $urandom_range(1, 3);
      if ((pick & 1) != 0 && !active[0]) drive_req(0, $urandom, 8'($urandom_range(0, 5)));
      if ((pick & 2) != 0 && !active[1]) drive_req(1, $urandom, 8'($urandom_range(0, 5)));
      do_burst($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
